// File: rtl/apb_master_arb_if.sv
// Bundle of the two client request ports and the APB master bus.
// The arbiter uses the master modport; clients and the APB slave side use slave.
interface apb_master_arb_if #(
  parameter int DWID = 8,
  parameter int AWID = 32
);
  // requester 0
  logic            req0_valid;
  logic            req0_write;
  logic [AWID-1:0] req0_addr;
  logic [DWID-1:0] req0_wdata;
  logic            req0_done;
  logic [DWID-1:0] req0_rdata;
  logic            req0_err;
  // requester 1
  logic            req1_valid;
  logic            req1_write;
  logic [AWID-1:0] req1_addr;
  logic [DWID-1:0] req1_wdata;
  logic            req1_done;
  logic [DWID-1:0] req1_rdata;
  logic            req1_err;
  // APB master bus
  logic            m_psel;
  logic            m_penable;
  logic            m_pwrite;
  logic [AWID-1:0] m_paddr;
  logic [DWID-1:0] m_pwdata;
  logic            m_pready;
  logic            m_pslverr;
  logic [DWID-1:0] m_prdata;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_done, req1_rdata, req1_err,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_pready, m_pslverr, m_prdata
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_done, req1_rdata, req1_err,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_pready, m_pslverr, m_prdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master. One transfer at a time through
// SETUP/ACCESS, with a pready timeout that completes the transfer with err=1.
module apb_master_arb #(
  parameter int DWID    = 8,
  parameter int AWID    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb_master_arb_if.master     bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  state_t                    state_q, state_d;
  logic                      last_q, last_d;
  logic                      gnt_q, gnt_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [AWID-1:0]           paddr_q, paddr_d;
  logic [DWID-1:0]           pwdata_q, pwdata_d;
  logic [1:0]                done_q, done_d;
  logic [1:0]                err_q, err_d;
  logic [1:0][DWID-1:0]      rdata_q, rdata_d;

  logic [1:0]                valid;
  logic                      gnt_sel;
  logic                      timeout_hit;

  assign valid       = {bus.req1_valid, bus.req0_valid};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL);

  // Next-state, arbitration and bus register updates
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = 2'b00;
    err_d     = err_q;
    rdata_d   = rdata_q;
    gnt_sel   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|valid) begin
          // both valid: the one not served last; otherwise the only one valid
          gnt_sel   = (valid == 2'b11) ? ~last_q : valid[1];
          gnt_d     = gnt_sel;
          paddr_d   = gnt_sel ? bus.req1_addr  : bus.req0_addr;
          pwrite_d  = gnt_sel ? bus.req1_write : bus.req0_write;
          pwdata_d  = gnt_sel ? bus.req1_wdata : bus.req0_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 16'd0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.m_pready || timeout_hit) begin
          // pready wins over a coincident timeout
          state_d        = IDLE;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          pwrite_d       = 1'b0;
          pwdata_d       = '0;
          done_d[gnt_q]  = 1'b1;
          rdata_d[gnt_q] = bus.m_pready ? bus.m_prdata : '0;
          err_d[gnt_q]   = bus.m_pready ? bus.m_pslverr : 1'b1;
          last_d         = gnt_q;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= 16'd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.m_psel     = psel_q;
  assign bus.m_penable  = penable_q;
  assign bus.m_pwrite   = pwrite_q;
  assign bus.m_paddr    = paddr_q;
  assign bus.m_pwdata   = pwdata_q;
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: vector table plus hand sequences, done pulses
// checked against a scoreboard queue filled when each request is driven.
module tb_apb_master_arb;

  logic clk;
  logic rst_n;

  apb_master_arb_if #(.DWID(8), .AWID(32)) bus ();
  apb_master_arb_if #(.DWID(8), .AWID(32)) bus_to ();

  apb_master_arb #(.DWID(8), .AWID(32), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  apb_master_arb #(.DWID(8), .AWID(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          req;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    int          waits;
    logic [7:0]  prdata;
    bit          slverr;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic       req;
    logic [7:0] rdata;
    logic       err;
  } sb_t;

  sb_t  exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic done_of(input bit r);
    return r ? bus.req1_done : bus.req0_done;
  endfunction

  task automatic drive_req(input bit r, input bit v, input bit w,
                           input logic [31:0] a, input logic [7:0] d);
    if (!r) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic push_exp(input bit r, input logic [7:0] rd, input bit e);
    sb_t s;
    s.req = r; s.rdata = rd; s.err = e;
    exp_q.push_back(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    sb_t e;
    if (bus.req0_done || bus.req1_done) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", {bus.req1_done, bus.req0_done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_both_done", bus.req0_done & bus.req1_done, 64'd0);
        chk("sb_req", bus.req1_done, e.req);
        chk("sb_rdata", e.req ? bus.req1_rdata : bus.req0_rdata, e.rdata);
        chk("sb_err", e.req ? bus.req1_err : bus.req0_err, e.err);
        $display("[TB] done req%0d rdata=%0h err=%0b", e.req,
                 e.req ? bus.req1_rdata : bus.req0_rdata,
                 e.req ? bus.req1_err : bus.req0_err);
      end
    end
  end

  // One table transfer: latency, bus stability and post-completion IDLE
  task automatic xfer(input vec_t v);
    drive_req(v.req, 1'b1, v.wr, v.addr, v.wdata);
    push_exp(v.req, v.exp_rdata, v.exp_err);
    bus.m_pready = 1'b0;
    step();  // edge 1
    chk("setup_psel", bus.m_psel, 1);
    chk("setup_penable", bus.m_penable, 0);
    chk("setup_paddr", bus.m_paddr, v.addr);
    chk("setup_pwrite", bus.m_pwrite, v.wr);
    chk("setup_pwdata", bus.m_pwdata, v.wdata);
    step();  // edge 2
    chk("access_penable", bus.m_penable, 1);
    chk("access_psel", bus.m_psel, 1);
    for (int c = 0; c <= v.waits; c++) begin
      bus.m_pready  = (c == v.waits);
      bus.m_prdata  = (c == v.waits) ? v.prdata : 8'hEE;
      bus.m_pslverr = (c == v.waits) ? v.slverr : 1'b0;
      step();
      if (c < v.waits) begin
        chk("wait_nodone", done_of(v.req), 0);
        chk("wait_penable", bus.m_penable, 1);
        chk("wait_paddr", bus.m_paddr, v.addr);
        chk("wait_pwrite", bus.m_pwrite, v.wr);
        chk("wait_pwdata", bus.m_pwdata, v.wdata);
      end else begin
        chk("done_edge", done_of(v.req), 1);
      end
    end
    drive_req(v.req, 1'b0, v.wr, v.addr, v.wdata);
    bus.m_pready = 1'b0; bus.m_pslverr = 1'b0;
    chk("idle_psel", bus.m_psel, 0);
    chk("idle_penable", bus.m_penable, 0);
    chk("idle_pwrite", bus.m_pwrite, 0);
    chk("idle_pwdata", bus.m_pwdata, 0);
    $display("[TB] xfer req%0d wr=%0b addr=%0h waits=%0d", v.req, v.wr, v.addr, v.waits);
    step();
  endtask

  initial begin
    //                req wr addr        wdata  waits prdata slverr exp_rd exp_err
    vecs[0] = '{1'b0, 1'b0, 32'h1004, 8'h00, 0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h4008, 8'h5A, 5, 8'h77, 1'b1, 8'h77, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h0010, 8'hC3, 2, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0020, 8'h00, 1, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0030, 8'h00, 0, 8'h11, 1'b1, 8'h11, 1'b1};

    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 8'h0);
    bus.m_pready = 1'b0; bus.m_pslverr = 1'b0; bus.m_prdata = 8'h00;
    bus_to.req0_valid = 1'b0; bus_to.req0_write = 1'b0;
    bus_to.req0_addr = 32'h0; bus_to.req0_wdata = 8'h0;
    bus_to.req1_valid = 1'b0; bus_to.req1_write = 1'b0;
    bus_to.req1_addr = 32'h0; bus_to.req1_wdata = 8'h0;
    bus_to.m_pready = 1'b0; bus_to.m_pslverr = 1'b0; bus_to.m_prdata = 8'h00;

    // reset values
    step(); step();
    chk("rst_psel", bus.m_psel, 0);
    chk("rst_penable", bus.m_penable, 0);
    chk("rst_pwrite", bus.m_pwrite, 0);
    chk("rst_paddr", bus.m_paddr, 0);
    chk("rst_pwdata", bus.m_pwdata, 0);
    chk("rst_done", {bus.req1_done, bus.req0_done}, 0);
    chk("rst_err", {bus.req1_err, bus.req0_err}, 0);
    chk("rst_rdata", {bus.req1_rdata, bus.req0_rdata}, 0);
    rst_n = 1'b1;
    step();

    // round-robin: both valid continuously, first grant to req0
    for (int k = 0; k < 4; k++) push_exp(k[0], 8'h42, 1'b0);
    bus.m_pready = 1'b1; bus.m_prdata = 8'h42;
    drive_req(1'b0, 1'b1, 1'b1, 32'h2000, 8'h01);
    drive_req(1'b1, 1'b1, 1'b1, 32'h3000, 8'h02);
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("rr_psel", bus.m_psel, ((e - 1) % 3) != 2);
      chk("rr_penable", bus.m_penable, ((e - 1) % 3) == 1);
      if (((e - 1) % 3) == 0) begin
        chk("rr_paddr", bus.m_paddr, (((e - 1) / 3) % 2 == 0) ? 32'h2000 : 32'h3000);
        $display("[TB] rr transfer %0d paddr=%0h", (e - 1) / 3, bus.m_paddr);
      end
    end
    drive_req(1'b0, 1'b0, 1'b1, 32'h2000, 8'h01);
    drive_req(1'b1, 1'b0, 1'b1, 32'h3000, 8'h02);
    bus.m_pready = 1'b0;
    step();
    chk("rr_stop_psel", bus.m_psel, 0);

    // table vectors
    for (int i = 0; i < 5; i++) xfer(vecs[i]);

    // req0 changes addr and drops valid during SETUP
    drive_req(1'b0, 1'b1, 1'b0, 32'h1111, 8'h00);
    push_exp(1'b0, 8'h0F, 1'b0);
    step();
    drive_req(1'b0, 1'b0, 1'b0, 32'h2222, 8'h00);
    step();
    chk("chg_paddr", bus.m_paddr, 32'h1111);
    chk("chg_penable", bus.m_penable, 1);
    bus.m_pready = 1'b1; bus.m_prdata = 8'h0F;
    step();
    chk("chg_done", bus.req0_done, 1);
    bus.m_pready = 1'b0;
    step();
    chk("chg_no_restart", bus.m_psel, 0);
    $display("[TB] mid-setup change transfer complete");

    // async reset during ACCESS; last completed was req0, so without reset
    // a both-valid request would go to req1
    drive_req(1'b1, 1'b1, 1'b0, 32'h5000, 8'h00);
    step(); step();
    chk("abort_in_access", bus.m_penable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_psel", bus.m_psel, 0);
    chk("arst_penable", bus.m_penable, 0);
    chk("arst_done", {bus.req1_done, bus.req0_done}, 0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h5000, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    drive_req(1'b0, 1'b1, 1'b0, 32'h6000, 8'h00);
    drive_req(1'b1, 1'b1, 1'b0, 32'h7000, 8'h00);
    push_exp(1'b0, 8'h5C, 1'b0);
    step();
    chk("rst_grant_paddr", bus.m_paddr, 32'h6000);
    drive_req(1'b1, 1'b0, 1'b0, 32'h7000, 8'h00);
    step();
    bus.m_pready = 1'b1; bus.m_prdata = 8'h5C;
    step();
    chk("rst_grant_done", bus.req0_done, 1);
    drive_req(1'b0, 1'b0, 1'b0, 32'h6000, 8'h00);
    bus.m_pready = 1'b0;
    step();
    $display("[TB] reset abort and regrant complete");

    // TIMEOUT=4 instance, slave never ready
    bus_to.req0_valid = 1'b1; bus_to.req0_addr = 32'h40;
    bus_to.m_prdata = 8'hFF;
    step(); step();
    chk("to_penable", bus_to.m_penable, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 5) chk("to_nodone", bus_to.req0_done, 0);
    end
    chk("to_done", bus_to.req0_done, 1);
    chk("to_err", bus_to.req0_err, 1);
    chk("to_rdata", bus_to.req0_rdata, 0);
    chk("to_psel", bus_to.m_psel, 0);
    bus_to.req0_valid = 1'b0;
    step();
    chk("to_err_hold", bus_to.req0_err, 1);
    chk("to_done_pulse", bus_to.req0_done, 0);
    $display("[TB] timeout transfer done err=%0b", bus_to.req0_err);
    bus_to.req0_valid = 1'b1; bus_to.req0_addr = 32'h44;
    step(); step();
    bus_to.m_pready = 1'b1; bus_to.m_prdata = 8'h3C;
    step();
    chk("to_next_done", bus_to.req0_done, 1);
    chk("to_next_err", bus_to.req0_err, 0);
    chk("to_next_rdata", bus_to.req0_rdata, 8'h3C);
    bus_to.req0_valid = 1'b0; bus_to.m_pready = 1'b0;
    $display("[TB] post-timeout transfer rdata=%0h", bus_to.req0_rdata);
    step(); step();

    chk("sb_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
